// File: rtl/riscv_decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, funct3 encodings, ALU ops and the
// 20-bit control bundle consumed by execute.
package riscv_decode_stage_pkg;

    typedef enum logic [6:0] {
        op_load   = 7'b0000011,
        op_imm    = 7'b0010011,
        op_auipc  = 7'b0010111,
        op_store  = 7'b0100011,
        op_reg    = 7'b0110011,
        op_lui    = 7'b0110111,
        op_branch = 7'b1100011,
        op_jalr   = 7'b1100111,
        op_jal    = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        br_beq  = 3'b000,
        br_bne  = 3'b001,
        br_blt  = 3'b100,
        br_bge  = 3'b101,
        br_bltu = 3'b110,
        br_bgeu = 3'b111
    } branch_f3_t;

    typedef enum logic [2:0] {
        ls_b  = 3'b000,
        ls_h  = 3'b001,
        ls_w  = 3'b010,
        ls_d  = 3'b011,
        ls_bu = 3'b100,
        ls_hu = 3'b101,
        ls_wu = 3'b110
    } lsu_f3_t;

    localparam logic [2:0] f3_add = 3'b000;
    localparam logic [2:0] f3_sr  = 3'b101;

    typedef enum logic [3:0] {
        alu_add  = 4'b0000,
        alu_sub  = 4'b0001,
        alu_sll  = 4'b0010,
        alu_slt  = 4'b0011,
        alu_sltu = 4'b0100,
        alu_xor  = 4'b0101,
        alu_srl  = 4'b0110,
        alu_sra  = 4'b0111,
        alu_or   = 4'b1000,
        alu_and  = 4'b1001,
        alu_ndef = 4'b1111
    } aluop_t;

    typedef struct packed {
        logic       branch;
        logic [2:0] branch_cond;
        logic       jump;
        logic       jalr;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       alu_a_pc;
        logic       lui;
        aluop_t     alu_op;
    } riscv_ctrl_v2_t;

    // alt selects sub for add and arithmetic for right shifts
    function automatic aluop_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? alu_sub : alu_add;
            3'b001:  return alu_sll;
            3'b010:  return alu_slt;
            3'b011:  return alu_sltu;
            3'b100:  return alu_xor;
            3'b101:  return alt ? alu_sra : alu_srl;
            3'b110:  return alu_or;
            default: return alu_and;
        endcase
    endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// Combinational RV32I/RV64I decoder: instruction word to control bundle,
// sign-extended immediate, register indices and illegal flag.
module riscv_decode_comb
    import riscv_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output riscv_ctrl_v2_t  ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            illegal
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               legal;
    riscv_ctrl_v2_t     c;
    logic signed [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    always_comb begin
        c        = '0;
        c.alu_op = alu_add;
        legal    = 1'b1;
        imm32    = '0;
        case (opcode)
            op_reg: begin
                c.reg_write = 1'b1;
                if (funct7 == 7'b0000000)
                    c.alu_op = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == f3_add || funct3 == f3_sr))
                    c.alu_op = alu_from_funct3(funct3, 1'b1);
                else
                    legal = 1'b0;
            end
            op_imm: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = alu_from_funct3(funct3, (funct3 == f3_sr) & funct7[5]);
                imm32       = {{20{instr[31]}}, instr[31:20]};
            end
            op_load: begin
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_size   = funct3;
                imm32        = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    ls_b, ls_h, ls_w, ls_bu, ls_hu: legal = 1'b1;
                    ls_d, ls_wu:                    legal = (XLEN == 64);
                    default:                        legal = 1'b0;
                endcase
            end
            op_store: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_size  = funct3;
                imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                case (funct3)
                    ls_b, ls_h, ls_w: legal = 1'b1;
                    ls_d:             legal = (XLEN == 64);
                    default:          legal = 1'b0;
                endcase
            end
            op_branch: begin
                c.branch      = 1'b1;
                c.branch_cond = funct3;
                c.alu_op      = alu_sub;
                imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                case (funct3)
                    br_beq, br_bne, br_blt, br_bge, br_bltu, br_bgeu: legal = 1'b1;
                    default:                                         legal = 1'b0;
                endcase
            end
            op_jal: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            op_jalr: begin
                c.jump      = 1'b1;
                c.jalr      = 1'b1;
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                legal       = (funct3 == 3'b000);
            end
            op_lui: begin
                c.lui       = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                imm32       = {instr[31:12], 12'b0};
            end
            op_auipc: begin
                c.alu_a_pc  = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                imm32       = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (instr[1:0] != 2'b11)
            legal = 1'b0;
        // Illegal entries carry a neutral bundle so execute never acts on them
        if (!legal) begin
            c        = '0;
            c.alu_op = alu_ndef;
        end
    end

    assign ctrl    = c;
    assign illegal = !legal;
    assign imm     = XLEN'(imm32);

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered decode stage: valid/ready handshake around riscv_decode_comb with an
// optional skid entry so back-pressure never costs throughput.
module riscv_decode_stage
    import riscv_decode_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ENABLE_SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output riscv_ctrl_v2_t  ctrl_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    typedef struct packed {
        riscv_ctrl_v2_t  ctrl;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } entry_t;

    riscv_ctrl_v2_t  dec_ctrl_p0;
    logic [XLEN-1:0] dec_imm_p0;
    logic [4:0]      dec_rs1_p0;
    logic [4:0]      dec_rs2_p0;
    logic [4:0]      dec_rd_p0;
    logic            dec_ill_p0;
    entry_t          ent_p0;

    entry_t out_p1;
    entry_t skid_p1;
    logic   vld_p1;
    logic   skid_vld_p1;
    logic   rdy_q;
    logic   out_free;
    logic   in_fire;

    riscv_decode_comb #(
        .XLEN(XLEN)
    ) u_decode (
        .instr   (instr_i),
        .ctrl    (dec_ctrl_p0),
        .imm     (dec_imm_p0),
        .rs1     (dec_rs1_p0),
        .rs2     (dec_rs2_p0),
        .rd      (dec_rd_p0),
        .illegal (dec_ill_p0)
    );

    always_comb begin
        ent_p0         = '0;
        ent_p0.ctrl    = dec_ctrl_p0;
        ent_p0.imm     = dec_imm_p0;
        ent_p0.rs1     = dec_rs1_p0;
        ent_p0.rs2     = dec_rs2_p0;
        ent_p0.rd      = dec_rd_p0;
        ent_p0.pc      = pc_i;
        ent_p0.illegal = dec_ill_p0;
    end

    assign out_free      = !vld_p1 | dec_ready_i;
    assign instr_ready_o = (ENABLE_SKID != 0) ? rdy_q : (out_free & !rst);
    assign in_fire       = instr_valid_i & instr_ready_o;

    // ---- stage p0 -> p1: output register plus skid entry ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_q       <= 1'b0;
            out_p1      <= '0;
            skid_p1     <= '0;
        end else if (flush_i) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_q       <= 1'b1;
        end else if (skid_vld_p1) begin
            // Ready is low while the skid is full, so no input can arrive here
            if (dec_ready_i) begin
                out_p1      <= skid_p1;
                skid_vld_p1 <= 1'b0;
                rdy_q       <= 1'b1;
            end
        end else if (out_free) begin
            vld_p1 <= in_fire;
            rdy_q  <= 1'b1;
            if (in_fire)
                out_p1 <= ent_p0;
        end else if (ENABLE_SKID != 0 && in_fire) begin
            skid_p1     <= ent_p0;
            skid_vld_p1 <= 1'b1;
            rdy_q       <= 1'b0;
        end
    end

    assign dec_valid_o = vld_p1;
    assign ctrl_o      = out_p1.ctrl;
    assign imm_o       = out_p1.imm;
    assign rs1_o       = out_p1.rs1;
    assign rs2_o       = out_p1.rs2;
    assign rd_o        = out_p1.rd;
    assign pc_o        = out_p1.pc;
    assign illegal_o   = out_p1.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed decode/handshake cases, then random
// traffic against a queue-based reference model.
module tb_riscv_decode_stage;

    typedef struct packed {
        logic [19:0] ctrl;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    localparam logic [3:0] ALU_OF_F3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    riscv_decode_stage_pkg::riscv_ctrl_v2_t ctrl_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] pc_o;
    logic        illegal_o;
    logic [19:0] ctrl_bits;

    logic        flush64 = 1'b0;
    logic        v64, rdy64, dv64, dr64, ill64;
    logic [31:0] ins64;
    logic [63:0] pc64, imm64, pco64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    riscv_decode_stage_pkg::riscv_ctrl_v2_t ctrl64;
    logic [19:0] ctrl64_bits;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    assign ctrl_bits   = ctrl_o;
    assign ctrl64_bits = ctrl64;

    always #5 clk = ~clk;

    riscv_decode_stage #(.XLEN(32), .ENABLE_SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .ctrl_o(ctrl_o), .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
        .pc_o(pc_o), .illegal_o(illegal_o)
    );

    riscv_decode_stage #(.XLEN(64), .ENABLE_SKID(0)) u_dut64 (
        .clk(clk), .rst(rst), .flush_i(flush64),
        .instr_valid_i(v64), .instr_ready_o(rdy64),
        .instr_i(ins64), .pc_i(pc64),
        .dec_valid_o(dv64), .dec_ready_i(dr64),
        .ctrl_o(ctrl64), .imm_o(imm64), .rs1_o(rs1_64), .rs2_o(rs2_64), .rd_o(rd_64),
        .pc_o(pco64), .illegal_o(ill64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_entry(input string t, input exp_t e);
        check_eq({t, ".valid"}, 64'(dec_valid_o), 64'(1));
        check_eq({t, ".ctrl"},  64'(ctrl_bits),   64'(e.ctrl));
        check_eq({t, ".imm"},   64'(imm_o),       64'(e.imm));
        check_eq({t, ".rs1"},   64'(rs1_o),       64'(e.rs1));
        check_eq({t, ".rs2"},   64'(rs2_o),       64'(e.rs2));
        check_eq({t, ".rd"},    64'(rd_o),        64'(e.rd));
        check_eq({t, ".pc"},    64'(pc_o),        64'(e.pc));
        check_eq({t, ".ill"},   64'(illegal_o),   64'(e.ill));
    endtask

    function automatic exp_t mk_exp(input logic [19:0] c, input logic [31:0] imm,
                                    input logic [31:0] w, input logic [31:0] pc, input logic ill);
        exp_t e;
        e.ctrl = c; e.imm = imm; e.pc = pc; e.ill = ill;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        return e;
    endfunction

    // Reference decode for XLEN=32 built from the ISA rules with plain arithmetic
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        bit legal = 1, br = 0, jmp = 0, jr = 0, mr = 0, mw = 0, m2r = 0, rw = 0, src = 0, apc = 0, lu = 0;
        logic [2:0] sz = 3'd0, cond = 3'd0;
        logic [3:0] alu = 4'd0;
        longint imm = 0;
        case (op)
            'h33: begin
                rw = 1;
                legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                alu = ALU_OF_F3[f3];
                if (f7 == 'h20 && f3 == 0) alu = 4'd1;
                if (f7 == 'h20 && f3 == 5) alu = 4'd7;
            end
            'h13: begin
                rw = 1; src = 1;
                alu = (f3 == 5 && w[30]) ? 4'd7 : ALU_OF_F3[f3];
                imm = longint'(w[31:20]) - (w[31] ? 4096 : 0);
            end
            'h03: begin
                mr = 1; m2r = 1; rw = 1; src = 1; sz = w[14:12];
                legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                imm = longint'(w[31:20]) - (w[31] ? 4096 : 0);
            end
            'h23: begin
                mw = 1; src = 1; sz = w[14:12];
                legal = (f3 <= 2);
                imm = longint'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
            end
            'h63: begin
                br = 1; cond = w[14:12]; alu = 4'd1;
                legal = !(f3 == 2 || f3 == 3);
                imm = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 8192 : 0);
            end
            'h6F: begin
                jmp = 1; rw = 1;
                imm = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? 64'd2097152 : 64'd0);
            end
            'h67: begin
                jmp = 1; jr = 1; rw = 1; src = 1;
                legal = (f3 == 0);
                imm = longint'(w[31:20]) - (w[31] ? 4096 : 0);
            end
            'h37: begin lu = 1; src = 1; rw = 1; imm = longint'(w[31:12]) * 4096; end
            'h17: begin apc = 1; src = 1; rw = 1; imm = longint'(w[31:12]) * 4096; end
            default: legal = 0;
        endcase
        if (w[1:0] != 2'b11) legal = 0;
        e = mk_exp(20'h0000F, imm[31:0], w, pc, 1'b1);
        if (legal) begin
            e.ctrl = {br, cond, jmp, jr, mr, mw, sz, m2r, rw, src, apc, lu, alu};
            e.ill  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 11);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: begin w[6:0] = 7'h67; if ($urandom_range(0, 1) == 1) w[14:12] = 3'd0; end
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7, 8: w[6:0] = 7'h33;
            9: w[6:0] = 7'h13;
            default: ;
        endcase
        if (k >= 7 && k <= 9) begin
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    function automatic logic [31:0] mk_addi(input logic [4:0] rd);
        return {12'd1, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        instr_valid_i = 1'b1; instr_i = w; pc_i = pc; dec_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic send64(input logic [31:0] w);
        v64 = 1'b1; ins64 = w; pc64 = 64'h8000_0000_0000_0040;
        @(posedge clk); #1;
        v64 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0; dec_ready_i = 1'b1;
        v64 = 1'b0; ins64 = '0; pc64 = '0; dr64 = 1'b1;
        #1;
        check_eq("rst.valid", 64'(dec_valid_o), 64'(0));
        check_eq("rst.ready", 64'(instr_ready_o), 64'(0));
        check_eq("rst.ctrl",  64'(ctrl_bits), 64'(0));
        check_eq("rst.imm",   64'(imm_o), 64'(0));
        check_eq("rst.pc",    64'(pc_o), 64'(0));
        check_eq("rst.ill",   64'(illegal_o), 64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("post_rst.ready", 64'(instr_ready_o), 64'(1));

        send(32'h002081B3, 32'h100);
        check_entry("add", mk_exp(20'h00080, 32'h0, 32'h002081B3, 32'h100, 1'b0));
        send(32'h40208133, 32'h104);
        check_entry("sub", mk_exp(20'h00081, 32'h0, 32'h40208133, 32'h104, 1'b0));
        send(32'h02208133, 32'h108);
        check_entry("bad_f7", mk_exp(20'h0000F, 32'h0, 32'h02208133, 32'h108, 1'b1));
        send(32'hFFC0A283, 32'h10C);
        check_entry("lw", mk_exp(20'h025C0, 32'hFFFF_FFFC, 32'hFFC0A283, 32'h10C, 1'b0));
        send(32'hFFC0B283, 32'h110);
        check_entry("ld32", mk_exp(20'h0000F, 32'hFFFF_FFFC, 32'hFFC0B283, 32'h110, 1'b1));
        send(32'hFE20CCE3, 32'h114);
        check_entry("blt", mk_exp(20'hC0001, 32'hFFFF_FFF8, 32'hFE20CCE3, 32'h114, 1'b0));

        // asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        check_eq("arst.valid", 64'(dec_valid_o), 64'(0));
        check_eq("arst.ready", 64'(instr_ready_o), 64'(0));
        check_eq("arst.ctrl",  64'(ctrl_bits), 64'(0));
        check_eq("arst.ill",   64'(illegal_o), 64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); @(negedge clk);

        send64(32'hFFC0A283);
        check_eq("lw64.ctrl", 64'(ctrl64_bits), 64'h25C0);
        check_eq("lw64.imm",  imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("lw64.ill",  64'(ill64), 64'(0));
        send64(32'hFFC0B283);
        check_eq("ld64.valid", 64'(dv64), 64'(1));
        check_eq("ld64.ctrl",  64'(ctrl64_bits), 64'h27C0);
        check_eq("ld64.ill",   64'(ill64), 64'(0));
        dr64 = 1'b0; #1;
        check_eq("noskid.ready_low", 64'(rdy64), 64'(0));
        dr64 = 1'b1; #1;
        check_eq("noskid.ready_high", 64'(rdy64), 64'(1));
        @(posedge clk); @(negedge clk);

        // back-pressure: three instructions with execute stalled
        dec_ready_i = 1'b0; instr_valid_i = 1'b1; pc_i = 32'h200;
        instr_i = mk_addi(5'd10); @(posedge clk); @(negedge clk);
        instr_i = mk_addi(5'd11); @(posedge clk); @(negedge clk);
        instr_i = mk_addi(5'd12);
        check_eq("bp.ready_drop", 64'(instr_ready_o), 64'(0));
        check_eq("bp.first", 64'(rd_o), 64'(10));
        @(posedge clk); @(negedge clk);
        check_eq("bp.hold_rd", 64'(rd_o), 64'(10));
        check_eq("bp.hold_valid", 64'(dec_valid_o), 64'(1));
        dec_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("bp.second", 64'(rd_o), 64'(11));
        check_eq("bp.ready_back", 64'(instr_ready_o), 64'(1));
        @(posedge clk); @(negedge clk);
        check_eq("bp.third", 64'(rd_o), 64'(12));
        instr_valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("bp.no_dup", 64'(dec_valid_o), 64'(0));

        // flush with skid full and an instruction on the input
        dec_ready_i = 1'b0; instr_valid_i = 1'b1;
        instr_i = mk_addi(5'd20); @(posedge clk); @(negedge clk);
        instr_i = mk_addi(5'd21); @(posedge clk); @(negedge clk);
        check_eq("fl.full", 64'(instr_ready_o), 64'(0));
        instr_i = mk_addi(5'd22); flush_i = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_i = 1'b0; instr_valid_i = 1'b0;
        check_eq("fl.valid", 64'(dec_valid_o), 64'(0));
        check_eq("fl.ready", 64'(instr_ready_o), 64'(1));
        dec_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq("fl.stays_empty", 64'(dec_valid_o), 64'(0));
        end
        // flush drops an input accepted in the same cycle
        instr_valid_i = 1'b1; instr_i = mk_addi(5'd23); flush_i = 1'b1;
        @(posedge clk); @(negedge clk);
        flush_i = 1'b0; instr_valid_i = 1'b0;
        check_eq("fl.drop_input", 64'(dec_valid_o), 64'(0));
        send(mk_addi(5'd24), 32'h300);
        check_eq("fl.recover", 64'(rd_o), 64'(24));
        @(posedge clk); @(negedge clk);

        // random traffic against the queue model
        exp_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic        vi, dr, fl;
            logic [31:0] w, pc;
            check_eq("rnd.ready", 64'(instr_ready_o), 64'(exp_q.size() < 2));
            check_eq("rnd.valid", 64'(dec_valid_o), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check_entry("rnd", exp_q[0]);
            vi = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 31) == 0);
            w  = gen_instr();
            pc = $urandom & 32'hFFFF_FFFC;
            instr_valid_i = vi; instr_i = w; pc_i = pc; dec_ready_i = dr; flush_i = fl;
            #1;
            if (fl) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && dr)
                    void'(exp_q.pop_front());
                if (vi && instr_ready_o)
                    exp_q.push_back(ref_decode(w, pc));
            end
            @(posedge clk); @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
